apb_cmd_master: RTL and testbench

- Single-outstanding APB3 initiator, the master end of the APB interface that CoreGPIO and the other peripheral slaves sit on.
- Converts a valid/ready command stream (from a sequencer, CPU bridge or self-test engine) into APB setup/access transfers.
- Handles PREADY wait states and PSLVERR, and aborts stalled transfers with a timeout.
- Returns each transfer's result on a valid/ready response stream.

---
 rtl/apb_cmd_master.sv | 154 +++++++++++++++
 tb/tb_apb_cmd_master.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB3 initiator: turns a valid/ready command stream into
// APB setup/access transfers and returns each result on a valid/ready response stream.
module apb_cmd_master #(
    parameter int ADDR_WIDTH     = 8,
    parameter int APB_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic                  CMD_WRITE,
    input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
    input  logic [APB_WIDTH-1:0]  CMD_WDATA,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic [APB_WIDTH-1:0]  RSP_RDATA,
    output logic                  RSP_ERR,
    output logic                  RSP_TIMEOUT,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [APB_WIDTH-1:0]  PWDATA,
    input  logic [APB_WIDTH-1:0]  PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    // state  | meaning
    // IDLE   | ready for a command
    // SETUP  | APB setup phase, PSEL=1 PENABLE=0 (one cycle)
    // ACCESS | APB access phase, waiting for PREADY or timeout
    // RESP   | response held until RSP_READY
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    // Abort fires on the low-PREADY cycle that would bring the count to TIMEOUT_CYCLES.
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_t                state_q, state_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [APB_WIDTH-1:0]  pwdata_q, pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [APB_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;

    always_comb begin
        state_d       = state_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        wait_cnt_d    = wait_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (CMD_VALID) begin
                    pwrite_d  = CMD_WRITE;
                    paddr_d   = CMD_ADDR;
                    pwdata_d  = CMD_WDATA;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = S_SETUP;
                end
            end
            S_SETUP: begin
                penable_d  = 1'b1;
                wait_cnt_d = '0;
                state_d    = S_ACCESS;
            end
            S_ACCESS: begin
                if (PREADY) begin
                    rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
                    rsp_err_d     = PSLVERR;
                    rsp_timeout_d = 1'b0;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = S_RESP;
                end else if (TIMEOUT_CYCLES != 0) begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    if (wait_cnt_q == CNT_LAST) begin
                        rsp_rdata_d   = '0;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b1;
                        psel_d        = 1'b0;
                        penable_d     = 1'b0;
                        rsp_valid_d   = 1'b1;
                        state_d       = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (RSP_READY) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q       <= S_IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    assign CMD_READY   = (state_q == S_IDLE);
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign RSP_VALID   = rsp_valid_q;
    assign RSP_RDATA   = rsp_rdata_q;
    assign RSP_ERR     = rsp_err_q;
    assign RSP_TIMEOUT = rsp_timeout_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: table of single transfers plus hand-written
// sequences for reset, response backpressure/back-to-back and reset mid-access.
module tb_apb_cmd_master;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        CMD_VALID, CMD_READY, CMD_WRITE;
    logic [7:0]  CMD_ADDR;
    logic [31:0] CMD_WDATA;
    logic        RSP_VALID, RSP_READY;
    logic [31:0] RSP_RDATA;
    logic        RSP_ERR, RSP_TIMEOUT;
    logic        PSEL, PENABLE, PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        PREADY, PSLVERR;

    int total = 0;
    int bad   = 0;

    apb_cmd_master #(.ADDR_WIDTH(8), .APB_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
        .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA),
        .RSP_ERR(RSP_ERR), .RSP_TIMEOUT(RSP_TIMEOUT),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          waits;       // low-PREADY cycles before PREADY=1
        logic [31:0] prdata;
        logic        slverr;      // PSLVERR in the completing cycle
        logic        err_in_wait; // PSLVERR during wait cycles
        int          exp_acc;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int  k;
        bit  done;
        @(negedge PCLK);
        CMD_VALID = 1'b1; CMD_WRITE = v.wr; CMD_ADDR = v.addr; CMD_WDATA = v.wdata;
        RSP_READY = 1'b1; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = v.prdata;
        chk({tag, "_cmd_ready"}, 32'(CMD_READY), 32'd1);
        @(posedge PCLK); #1;
        CMD_VALID = 1'b0; CMD_WRITE = ~v.wr; CMD_ADDR = ~v.addr; CMD_WDATA = ~v.wdata;
        chk({tag, "_setup_psel"}, 32'(PSEL), 32'd1);
        chk({tag, "_setup_pen"}, 32'(PENABLE), 32'd0);
        chk({tag, "_setup_paddr"}, 32'(PADDR), 32'(v.addr));
        chk({tag, "_setup_pwrite"}, 32'(PWRITE), 32'(v.wr));
        chk({tag, "_setup_pwdata"}, PWDATA, v.wdata);
        @(posedge PCLK); #1;
        chk({tag, "_acc_psel"}, 32'(PSEL), 32'd1);
        chk({tag, "_acc_pen"}, 32'(PENABLE), 32'd1);
        k = 0;
        done = 1'b0;
        while (!done && k < 40) begin
            @(negedge PCLK);
            k++;
            PREADY  = (k == v.waits + 1);
            PSLVERR = PREADY ? v.slverr : v.err_in_wait;
            @(posedge PCLK); #1;
            if (!PSEL) done = 1'b1;
            else begin
                chk({tag, "_wait_pen"}, 32'(PENABLE), 32'd1);
                chk({tag, "_wait_paddr"}, 32'(PADDR), 32'(v.addr));
                chk({tag, "_wait_pwdata"}, PWDATA, v.wdata);
            end
        end
        chk({tag, "_completed"}, 32'(done), 32'd1);
        chk({tag, "_acc_cycles"}, 32'(k), 32'(v.exp_acc));
        chk({tag, "_pen_off"}, 32'(PENABLE), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(RSP_VALID), 32'd1);
        chk({tag, "_rsp_rdata"}, RSP_RDATA, v.exp_rdata);
        chk({tag, "_rsp_err"}, 32'(RSP_ERR), 32'(v.exp_err));
        chk({tag, "_rsp_to"}, 32'(RSP_TIMEOUT), 32'(v.exp_to));
        chk({tag, "_resp_cmd_ready"}, 32'(CMD_READY), 32'd0);
        PREADY = 1'b0; PSLVERR = 1'b0;
        @(posedge PCLK); #1;
        chk({tag, "_rsp_drop"}, 32'(RSP_VALID), 32'd0);
        chk({tag, "_idle_cmd_ready"}, 32'(CMD_READY), 32'd1);
    endtask

    initial begin
        //           wr    addr   wdata         waits prdata        slv   eiw   acc rdata         err   to
        vecs[0] = '{1'b1, 8'h01, 32'h0000005A, 0,   32'h12345678, 1'b0, 1'b0, 1,  32'h0,        1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'h00, 32'h0,        3,   32'hDEADBEEF, 1'b0, 1'b0, 4,  32'hDEADBEEF, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 8'h10, 32'hCAFEF00D, 0,   32'h0,        1'b1, 1'b0, 1,  32'h0,        1'b1, 1'b0};
        vecs[3] = '{1'b0, 8'h22, 32'h0,        2,   32'h0BADF00D, 1'b0, 1'b1, 3,  32'h0BADF00D, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 8'h33, 32'h0,        100, 32'hFFFFFFFF, 1'b0, 1'b0, 16, 32'h0,        1'b1, 1'b1};
        vecs[5] = '{1'b1, 8'h44, 32'h13572468, 15,  32'hFFFFFFFF, 1'b0, 1'b0, 16, 32'h0,        1'b0, 1'b0};
        vecs[6] = '{1'b0, 8'hFF, 32'h0,        14,  32'hA5A5A5A5, 1'b1, 1'b0, 15, 32'hA5A5A5A5, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 8'h80, 32'h0,        1,   32'h00C0FFEE, 1'b0, 1'b1, 2,  32'h00C0FFEE, 1'b0, 1'b0};

        PRESET = 1'b1;
        CMD_VALID = 1'b0; CMD_WRITE = 1'b0; CMD_ADDR = '0; CMD_WDATA = '0;
        RSP_READY = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        #12;
        chk("rst_psel", 32'(PSEL), 32'd0);
        chk("rst_pen", 32'(PENABLE), 32'd0);
        chk("rst_pwrite", 32'(PWRITE), 32'd0);
        chk("rst_paddr", 32'(PADDR), 32'd0);
        chk("rst_pwdata", PWDATA, 32'd0);
        chk("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
        chk("rst_rsp_rdata", RSP_RDATA, 32'd0);
        chk("rst_rsp_err", 32'(RSP_ERR), 32'd0);
        chk("rst_rsp_to", 32'(RSP_TIMEOUT), 32'd0);
        @(negedge PCLK);
        PRESET = 1'b0;
        #1;
        chk("rst_cmd_ready", 32'(CMD_READY), 32'd1);

        for (int i = 0; i < 8; i++)
            run_txn(vecs[i], $sformatf("v%0d", i));

        // Response backpressure with a second command waiting behind it.
        @(negedge PCLK);
        CMD_VALID = 1'b1; CMD_WRITE = 1'b0; CMD_ADDR = 8'h05; CMD_WDATA = '0;
        RSP_READY = 1'b0; PREADY = 1'b1; PRDATA = 32'h11223344;
        @(posedge PCLK); #1;
        CMD_WRITE = 1'b1; CMD_ADDR = 8'h06; CMD_WDATA = 32'h00000077;
        @(posedge PCLK); #1;
        chk("bp_acc_paddr", 32'(PADDR), 32'h05);
        @(posedge PCLK); #1;
        PRDATA = 32'h99999999;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp_rsp_valid_%0d", c), 32'(RSP_VALID), 32'd1);
            chk($sformatf("bp_rsp_rdata_%0d", c), RSP_RDATA, 32'h11223344);
            chk($sformatf("bp_cmd_ready_%0d", c), 32'(CMD_READY), 32'd0);
            chk($sformatf("bp_psel_%0d", c), 32'(PSEL), 32'd0);
            if (c < 4) begin
                @(posedge PCLK); #1;
            end
        end
        @(negedge PCLK);
        RSP_READY = 1'b1;
        @(posedge PCLK); #1;
        chk("bp_hs_rsp_valid", 32'(RSP_VALID), 32'd0);
        chk("bp_hs_cmd_ready", 32'(CMD_READY), 32'd1);
        chk("bp_hs_psel", 32'(PSEL), 32'd0);
        @(posedge PCLK); #1;
        CMD_VALID = 1'b0;
        chk("b2b_setup_psel", 32'(PSEL), 32'd1);
        chk("b2b_setup_pen", 32'(PENABLE), 32'd0);
        chk("b2b_setup_paddr", 32'(PADDR), 32'h06);
        chk("b2b_setup_pwrite", 32'(PWRITE), 32'd1);
        chk("b2b_setup_pwdata", PWDATA, 32'h00000077);
        @(posedge PCLK); #1;
        chk("b2b_acc_pen", 32'(PENABLE), 32'd1);
        @(posedge PCLK); #1;
        chk("b2b_rsp_valid", 32'(RSP_VALID), 32'd1);
        chk("b2b_rsp_rdata", RSP_RDATA, 32'd0);
        chk("b2b_rsp_err", 32'(RSP_ERR), 32'd0);
        @(posedge PCLK); #1;
        chk("b2b_idle", 32'(CMD_READY), 32'd1);

        // Reset asserted between clock edges during a wait-state access.
        @(negedge PCLK);
        CMD_VALID = 1'b1; CMD_WRITE = 1'b0; CMD_ADDR = 8'h5C; PREADY = 1'b0;
        @(posedge PCLK); #1;
        CMD_VALID = 1'b0;
        @(posedge PCLK);
        @(posedge PCLK); #1;
        chk("ra_in_access", 32'(PENABLE), 32'd1);
        @(negedge PCLK); #2;
        PRESET = 1'b1;
        #1;
        chk("ra_psel", 32'(PSEL), 32'd0);
        chk("ra_pen", 32'(PENABLE), 32'd0);
        chk("ra_rsp_valid", 32'(RSP_VALID), 32'd0);
        @(negedge PCLK);
        PRESET = 1'b0;
        PREADY = 1'b1;
        #1;
        chk("ra_cmd_ready", 32'(CMD_READY), 32'd1);
        @(posedge PCLK); #1;
        chk("ra_no_rsp", 32'(RSP_VALID), 32'd0);
        chk("ra_no_psel", 32'(PSEL), 32'd0);
        run_txn('{1'b0, 8'h5D, 32'h0, 1, 32'h76543210, 1'b0, 1'b0, 2, 32'h76543210, 1'b0, 1'b0}, "ra_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
